floor_ctrl: RTL and testbench



---
 rtl/floor_pkg.sv | 22 ++
 rtl/floor_if.sv | 22 ++
 rtl/floor_pit_lookup.sv | 17 +
 rtl/floor_ctrl.sv | 141 ++++++++++++++
 tb/tb_floor_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/floor_pkg.sv
// Shared constants and types for the level 1-1 ground layer: world geometry and pit table.
// Pure declarations: no logic, no latency, no flow control.
package floor_pkg;

  localparam logic [9:0]  FLOOR_TOP  = 10'd460;
  localparam logic [9:0]  SCREEN_H   = 10'd480;
  localparam logic [9:0]  SCREEN_W   = 10'd640;
  localparam logic [11:0] WORLD_W    = 12'd3392;
  localparam logic [11:0] MAX_SCROLL = 12'd2752;

  // Pits are half-open world-X intervals [start, end); entry 0 is the leftmost pit.
  localparam int NUM_PITS = 3;
  localparam logic [NUM_PITS-1:0][11:0] PIT_START = {12'd2448, 12'd1392, 12'd1104};
  localparam logic [NUM_PITS-1:0][11:0] PIT_END   = {12'd2480, 12'd1440, 12'd1136};

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } fsm_t;

endpackage

// File: rtl/floor_if.sv
// Collision query bus between the sprite requesters and the floor lookup arbiter.
// Requesters hold req/qx until gnt; the response strobe follows gnt by two cycles.
interface floor_if #(parameter int NUM_REQ = 3);

  logic [NUM_REQ-1:0]    req;
  logic [12*NUM_REQ-1:0] qx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic                  rsp_grounded;

  modport master (
    output req, qx,
    input  gnt, rsp_valid, rsp_id, rsp_grounded
  );

  modport slave (
    input  req, qx,
    output gnt, rsp_valid, rsp_id, rsp_grounded
  );

endinterface

// File: rtl/floor_pit_lookup.sv
// Combinational world-X pit test against the packaged pit table.
// Zero latency, no flow control.
module floor_pit_lookup
  import floor_pkg::*;
(
  input  logic [11:0] x,
  output logic        in_pit
);

  always_comb begin
    in_pit = 1'b0;
    for (int i = 0; i < NUM_PITS; i++) begin
      if (x >= PIT_START[i] && x < PIT_END[i]) in_pit = 1'b1;
    end
  end

endmodule

// File: rtl/floor_ctrl.sv
// Ground layer: camera scroll, 2-stage is_floor render path, round-robin world-X floor query.
// Query answers 2 cycles after gnt, one query per 3 cycles; requesters wait on gnt.
module floor_ctrl
  import floor_pkg::*;
#(
  parameter int NUM_REQ = 3
)
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_delta,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_floor,
  output logic [11:0] camera_x,
  floor_if.slave      q
);

  logic [12:0] cam_sum;
  logic [11:0] wx;
  logic        band;
  logic        render_pit;

  fsm_t        state;
  fsm_t        state_next;
  logic [1:0]  ptr;
  logic [1:0]  pick;
  logic [1:0]  ptr_next;
  logic [2:0]  cand;
  logic        found;
  logic [11:0] sel_qx;
  logic [11:0] q_x;
  logic        query_pit;
  logic        grant_en;

  // ---------------- camera ----------------
  assign cam_sum = {1'b0, camera_x} + {9'd0, scroll_delta};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      camera_x <= 12'd0;
    end else if (frame_start && scroll_en) begin
      camera_x <= (cam_sum > {1'b0, MAX_SCROLL}) ? MAX_SCROLL : cam_sum[11:0];
    end
  end

  // ---------------- render path ----------------
  floor_pit_lookup u_render_pit (
    .x      (wx),
    .in_pit (render_pit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wx       <= 12'd0;
      band     <= 1'b0;
      is_floor <= 1'b0;
    end else begin
      wx       <= camera_x + {2'b00, DrawX};
      band     <= (DrawY >= FLOOR_TOP) && (DrawY < SCREEN_H) && (DrawX < SCREEN_W);
      is_floor <= band && !render_pit;
    end
  end

  // ---------------- query arbiter ----------------
  // Scan from the pointer upward, wrapping, and take the first pending requester.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && q.req[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  assign ptr_next = (pick == 2'(NUM_REQ - 1)) ? 2'd0 : pick + 2'd1;

  always_comb begin
    sel_qx = 12'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 2'(i)) sel_qx = q.qx[12*i +: 12];
    end
  end

  floor_pit_lookup u_query_pit (
    .x      (q_x),
    .in_pit (query_pit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = LOOKUP;
      LOOKUP:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // gnt is combinational off req; masking with Reset keeps it quiet while reset is held.
  assign grant_en = (state == IDLE) && found && !Reset;

  always_comb begin
    q.gnt       = '0;
    q.rsp_valid = (state == RESP);
    for (int i = 0; i < NUM_REQ; i++) begin
      q.gnt[i] = grant_en && (pick == 2'(i));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr            <= 2'd0;
      q_x            <= 12'd0;
      q.rsp_id       <= 2'd0;
      q.rsp_grounded <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        ptr      <= ptr_next;
        q_x      <= sel_qx;
        q.rsp_id <= pick;
      end
      if (state == LOOKUP) begin
        q.rsp_grounded <= (q_x < WORLD_W) && !query_pit;
      end
    end
  end

endmodule

// File: tb/tb_floor_ctrl.sv
// Self-checking bench for floor_ctrl: directed scenarios plus randomized render/scroll and
// query traffic, compared against a behavioural model of camera, ground band, pits and arbitration.
module tb_floor_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        scroll_en = 1'b0;
  logic [3:0]  scroll_delta = 4'd0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic        is_floor;
  logic [11:0] camera_x;

  floor_if #(.NUM_REQ(3)) q ();

  floor_ctrl #(.NUM_REQ(3)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .scroll_en    (scroll_en),
    .scroll_delta (scroll_delta),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .is_floor     (is_floor),
    .camera_x     (camera_x),
    .q            (q)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_pit(input int x);
    return (x >= 1104 && x < 1136) || (x >= 1392 && x < 1440) || (x >= 2448 && x < 2480);
  endfunction

  function automatic bit m_floor(input int cam, input int x, input int y);
    return (y >= 460) && (y < 480) && (x < 640) && !m_pit(cam + x);
  endfunction

  function automatic bit m_grounded(input int x);
    return (x < 3392) && !m_pit(x);
  endfunction

  int cam_m = 0;

  // Query model: the lookup is busy for 3 cycles after each grant; answer lands 2 cycles later.
  int          cyc = 0;
  int          free_at = 0;
  int          rr = 0;
  int          rsp_t[$];
  int          rsp_idq[$];
  bit          rsp_gq[$];
  logic [2:0]  pend = 3'b000;
  logic [11:0] pqx[3];
  logic [2:0]  seen_gnt = 3'b000;
  logic [2:0]  last_gnt;
  logic        last_g;
  int          glist[$];
  int          gcyc[$];

  function automatic logic [11:0] rand_qx();
    int edges[14] = '{1103, 1104, 1135, 1136, 1391, 1392, 1439, 1440,
                      2447, 2448, 2479, 2480, 3391, 3392};
    case ($urandom_range(0, 3))
      0:       return 12'(edges[$urandom_range(0, 13)]);
      1:       return 12'($urandom_range(3392, 4095));
      default: return 12'($urandom_range(0, 3391));
    endcase
  endfunction

  task automatic model_reset();
    rsp_t.delete();
    rsp_idq.delete();
    rsp_gq.delete();
    free_at  = cyc;
    rr       = 0;
    pend     = 3'b000;
    seen_gnt = 3'b000;
    cam_m    = 0;
  endtask

  // mode 0: every requester always pending; 1: random new requests; 2: no new requests
  task automatic q_cycle(input int mode);
    logic [2:0] exp_gnt;
    bit         ev;
    int         w;
    @(posedge Clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (seen_gnt[i]) pend[i] = 1'b0;
      if (!pend[i] && (mode == 0 || (mode == 1 && $urandom_range(0, 2) == 0))) begin
        pend[i] = 1'b1;
        pqx[i]  = rand_qx();
      end
    end
    q.req = pend;
    q.qx  = {pqx[2], pqx[1], pqx[0]};
    exp_gnt = 3'b000;
    if (pend != 3'b000 && cyc >= free_at) begin
      for (int k = 0; k < 3; k++) begin
        w = (rr + k) % 3;
        if (exp_gnt == 3'b000 && pend[w]) exp_gnt[w] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (exp_gnt[i]) begin
          rsp_t.push_back(cyc + 2);
          rsp_idq.push_back(i);
          rsp_gq.push_back(m_grounded(int'(pqx[i])));
          rr = (i + 1) % 3;
        end
      end
      free_at = cyc + 3;
    end
    @(negedge Clk);
    chk("gnt", q.gnt, exp_gnt);
    seen_gnt = q.gnt;
    last_gnt = q.gnt;
    for (int i = 0; i < 3; i++) begin
      if (q.gnt[i]) begin
        glist.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    ev = (rsp_t.size() > 0) && (rsp_t[0] == cyc);
    chk("rsp_valid", q.rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", q.rsp_id, rsp_idq[0]);
      chk("rsp_grounded", q.rsp_grounded, rsp_gq[0]);
      last_g = q.rsp_grounded;
      void'(rsp_t.pop_front());
      void'(rsp_idq.pop_front());
      void'(rsp_gq.pop_front());
    end
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frame_start = 1'b0;
    q.req = 3'b000;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_camera_x", camera_x, 0);
    chk("rst_is_floor", is_floor, 0);
    chk("rst_gnt", q.gnt, 0);
    chk("rst_rsp_valid", q.rsp_valid, 0);
    chk("rst_rsp_id", q.rsp_id, 0);
    chk("rst_rsp_grounded", q.rsp_grounded, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic render_check(input int x, input int y, input bit expv, input string tag);
    @(posedge Clk); #1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    repeat (3) @(negedge Clk);
    chk(tag, is_floor, expv);
  endtask

  task automatic pulse(input bit en, input int d);
    @(posedge Clk); #1;
    frame_start  = 1'b1;
    scroll_en    = en;
    scroll_delta = 4'(d);
    @(posedge Clk); #1;
    frame_start = 1'b0;
    if (en) cam_m = (cam_m + d > 2752) ? 2752 : cam_m + d;
  endtask

  task automatic single(input int id, input int qxv, input bit expg, input string tag);
    last_g   = 1'bx;
    pend[id] = 1'b1;
    pqx[id]  = 12'(qxv);
    repeat (4) q_cycle(2);
    chk(tag, last_g, expg);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int hx[300];
  int hy[300];
  int hc[300];
  int exp_ids[4] = '{0, 1, 2, 0};

  initial begin
    bit fs, en;
    int d;
    q.req = 3'b000;
    q.qx  = '0;
    for (int i = 0; i < 3; i++) pqx[i] = 12'd0;

    do_reset();

    render_check(100, 465, 1'b1, "band_mid");
    render_check(100, 459, 1'b0, "above_band");
    render_check(100, 479, 1'b1, "band_last_row");
    render_check(100, 480, 1'b0, "below_band");

    for (int i = 0; i < 125; i++) pulse(1'b1, 8);
    chk("camera_1000", camera_x, 1000);
    render_check(110, 470, 1'b0, "pit_world_1110");
    render_check(140, 470, 1'b1, "ground_world_1140");

    for (int i = 0; i < 218; i++) pulse(1'b1, 8);
    pulse(1'b1, 6);
    chk("camera_2750", camera_x, 2750);
    pulse(1'b1, 15);
    chk("camera_sat", camera_x, 2752);
    pulse(1'b1, 15);
    chk("camera_sat_hold", camera_x, 2752);
    pulse(1'b0, 15);
    chk("camera_no_en", camera_x, 2752);
    render_check(639, 470, 1'b1, "last_col_world_3391");
    render_check(640, 470, 1'b0, "off_screen_col");

    // Round-robin with all three requesters held high
    do_reset();
    glist.delete();
    gcyc.delete();
    repeat (12) q_cycle(0);
    repeat (15) q_cycle(2);
    chk("rr_grant_count", glist.size() >= 4, 1);
    if (glist.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", glist[i], exp_ids[i]);
      chk("rr_spacing", gcyc[1] - gcyc[0], 3);
    end

    single(0, 1120, 1'b0, "q_1120");
    single(0, 1200, 1'b1, "q_1200");
    single(1, 1439, 1'b0, "q_1439");
    single(2, 1440, 1'b1, "q_1440");
    single(0, 4000, 1'b0, "q_4000");

    // Reset while the query is in LOOKUP: response must be dropped
    pend = 3'b001;
    pqx[0] = 12'd1200;
    q_cycle(2);
    @(posedge Clk); #1;
    Reset = 1'b1;
    q.req = 3'b000;
    pend  = 3'b000;
    @(negedge Clk);
    chk("midrst_gnt", q.gnt, 0);
    chk("midrst_rsp_valid", q.rsp_valid, 0);
    @(negedge Clk);
    chk("midrst_rsp_valid_late", q.rsp_valid, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    repeat (3) q_cycle(2);
    pend = 3'b110;
    pqx[1] = 12'd500;
    pqx[2] = 12'd1110;
    q_cycle(2);
    chk("midrst_first_gnt", last_gnt, 3'b010);
    repeat (12) q_cycle(2);

    // Random query traffic
    do_reset();
    repeat (300) q_cycle(1);
    repeat (15) q_cycle(2);

    // Random render with scrolling in flight
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(posedge Clk); #1;
      hx[c] = $urandom_range(0, 1023);
      hy[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(450, 490);
      hc[c] = cam_m;
      fs = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 1) == 1);
      d  = $urandom_range(0, 15);
      DrawX        = 10'(hx[c]);
      DrawY        = 10'(hy[c]);
      frame_start  = fs;
      scroll_en    = en;
      scroll_delta = 4'(d);
      @(negedge Clk);
      chk("rnd_camera_x", camera_x, cam_m);
      if (c >= 2) chk("rnd_is_floor", is_floor, m_floor(hc[c-2], hx[c-2], hy[c-2]));
      if (fs && en) cam_m = (cam_m + d > 2752) ? 2752 : cam_m + d;
    end
    @(posedge Clk); #1;
    frame_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
